// File: rtl/queue_pkg.sv
// Shared types and constants for the bank-queue subsystem: teller ids, dispatcher
// FSM states and the round-robin pick used by the call dispatcher.
package queue_pkg;

  localparam int         MAX_PEOPLE = 7;
  localparam int         N_TELLERS  = 3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ANNOUNCE
  } state_t;

  typedef logic [1:0] teller_id_t;

  // First requesting teller in the order ptr, ptr+1, ptr+2 (mod N_TELLERS).
  function automatic teller_id_t rr_pick(input logic [N_TELLERS-1:0] req,
                                         input teller_id_t ptr);
    teller_id_t idx;
    teller_id_t win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_TELLERS; k++) begin
      idx = teller_id_t'((int'(ptr) + k) % N_TELLERS);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Tick-sampled debouncer for one active-low push button; fall pulses for one clk
// on the clk edge where a new pressed level is accepted.
module button_debouncer #(
  parameter int DB_SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw_n,
  output logic level_n,
  output logic fall
);

  localparam int CW = $clog2(DB_SAMPLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          w_accept;

  // The raw button is asynchronous to clk, so it is synchronised before sampling.
  // NOTE: sequential state is assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], raw_n};
  end

  assign w_accept = tick && (r_sync[1] != r_level) && (r_cnt == CW'(DB_SAMPLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (tick) begin
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level_n = r_level;
  assign fall    = w_accept && r_level;

endmodule

// File: rtl/teller_call_dispatcher.sv
// Serves debounced teller "next" requests round-robin, one counter decrement per
// grant, and drives the called teller/ticket announcement outputs.
module teller_call_dispatcher
  import queue_pkg::*;
#(
  parameter int CLK_DIV    = 1_000_000,
  parameter int DB_SAMPLES = 3,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] next_n,
  input  logic [2:0] teller_en,
  input  logic [3:0] queue_count,
  output logic       dec_pulse,
  output logic       reject_pulse,
  output logic [1:0] called_teller,
  output logic [3:0] called_ticket,
  output logic [2:0] call_led,
  output logic       busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW    = $clog2(HOLD_TICKS + 1);

  logic [DIV_W-1:0]     r_div_cnt;
  logic                 w_tick;
  logic [N_TELLERS-1:0] w_level_n;
  logic [N_TELLERS-1:0] w_fall;
  logic                 w_unused_level;
  logic [N_TELLERS-1:0] r_pending;
  logic [N_TELLERS-1:0] w_grant_clr;
  logic                 w_reject;
  teller_id_t           w_pick;

  state_t               r_state;
  teller_id_t           r_ptr;
  teller_id_t           r_win;
  logic [HW-1:0]        r_hold_cnt;
  logic                 r_dec_pulse;
  logic                 r_reject_pulse;
  logic [1:0]           r_called_teller;
  logic [3:0]           r_called_ticket;
  logic [2:0]           r_call_led;
  logic                 r_busy;

  assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  for (genvar i = 0; i < N_TELLERS; i++) begin : g_db
    button_debouncer #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .tick    (w_tick),
      .raw_n   (next_n[i]),
      .level_n (w_level_n[i]),
      .fall    (w_fall[i])
    );
  end

  // Only the press edge matters here; the steady level is not used.
  assign w_unused_level = ^w_level_n;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_grant_clr = '0;
    if (r_state == GRANT) w_grant_clr[r_win] = 1'b1;
  end

  assign w_reject = (r_state == IDLE) && (r_pending != '0) && (queue_count == 4'd0);
  assign w_pick   = rr_pick(r_pending, r_ptr);

  // Closed desks are masked every cycle, so they can neither set nor keep a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_pending <= '0;
    else if (w_reject) r_pending <= w_fall & teller_en;
    else               r_pending <= (r_pending | w_fall) & teller_en & ~w_grant_clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_ptr           <= '0;
      r_win           <= '0;
      r_hold_cnt      <= '0;
      r_dec_pulse     <= 1'b0;
      r_reject_pulse  <= 1'b0;
      r_called_teller <= '0;
      r_called_ticket <= '0;
      r_call_led      <= '0;
      r_busy          <= 1'b0;
    end else begin
      r_dec_pulse    <= 1'b0;
      r_reject_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          // Outputs are loaded on entry so they are already valid during GRANT.
          if ((r_pending != '0) && (queue_count != 4'd0)) begin
            r_state         <= GRANT;
            r_win           <= w_pick;
            r_dec_pulse     <= 1'b1;
            r_called_teller <= w_pick + 2'd1;
            r_call_led      <= 3'(1) << w_pick;
            r_called_ticket <= (r_called_ticket == BCD_MAX) ? 4'd0 : r_called_ticket + 4'd1;
            r_ptr           <= (w_pick == teller_id_t'(N_TELLERS - 1)) ? '0 : w_pick + 2'd1;
            r_busy          <= 1'b1;
          end else if (w_reject) begin
            r_reject_pulse <= 1'b1;
          end
        end
        GRANT: begin
          r_state    <= ANNOUNCE;
          r_hold_cnt <= '0;
        end
        ANNOUNCE: begin
          if (w_tick) begin
            if (r_hold_cnt == HW'(HOLD_TICKS - 1)) begin
              r_state    <= IDLE;
              r_call_led <= '0;
              r_busy     <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dec_pulse     = r_dec_pulse;
  assign reject_pulse  = r_reject_pulse;
  assign called_teller = r_called_teller;
  assign called_ticket = r_called_ticket;
  assign call_led      = r_call_led;
  assign busy          = r_busy;

endmodule

// File: tb/tb_teller_call_dispatcher.sv
// Directed bench for teller_call_dispatcher with CLK_DIV=4, DB_SAMPLES=3, HOLD_TICKS=2.
module tb_teller_call_dispatcher;

  logic       clk;
  logic       reset;
  logic [2:0] next_n;
  logic [2:0] teller_en;
  logic [3:0] queue_count;
  logic       dec_pulse;
  logic       reject_pulse;
  logic [1:0] called_teller;
  logic [3:0] called_ticket;
  logic [2:0] call_led;
  logic       busy;

  int total     = 0;
  int bad       = 0;
  int dec_count = 0;
  int rej_count = 0;
  int exp_dec   = 0;
  int exp_ticket;

  teller_call_dispatcher #(
    .CLK_DIV    (4),
    .DB_SAMPLES (3),
    .HOLD_TICKS (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .next_n        (next_n),
    .teller_en     (teller_en),
    .queue_count   (queue_count),
    .dec_pulse     (dec_pulse),
    .reject_pulse  (reject_pulse),
    .called_teller (called_teller),
    .called_ticket (called_ticket),
    .call_led      (call_led),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (dec_pulse === 1'b1)    dec_count++;
    if (reject_pulse === 1'b1) rej_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dec"},    32'(dec_pulse),     0);
    check({tag, "_rej"},    32'(reject_pulse),  0);
    check({tag, "_teller"}, 32'(called_teller), 0);
    check({tag, "_ticket"}, 32'(called_ticket), 0);
    check({tag, "_led"},    32'(call_led),      0);
    check({tag, "_busy"},   32'(busy),          0);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (dec_pulse !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant_seen"}, 32'(dec_pulse), 1);
  endtask

  task automatic check_grant(input string tag, input int teller, input int ticket);
    check({tag, "_teller"}, 32'(called_teller), teller);
    check({tag, "_ticket"}, 32'(called_ticket), ticket);
    check({tag, "_led"},    32'(call_led),      1 << (teller - 1));
    check({tag, "_busy"},   32'(busy),          1);
  endtask

  // Called on the grant cycle; walks the announcement until busy drops.
  task automatic hold_announce(input string tag, input int teller);
    int n;
    int led_bad;
    n       = 1;
    led_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      if (call_led !== 3'(1 << (teller - 1))) led_bad++;
      if (dec_pulse === 1'b1) led_bad++;
    end
    check({tag, "_busy_len_ok"}, 32'((n >= 6) && (n <= 9)), 1);
    check({tag, "_led_held"},    32'(led_bad), 0);
    check({tag, "_led_off"},     32'(call_led), 0);
    check({tag, "_teller_kept"}, 32'(called_teller), teller);
  endtask

  initial begin
    reset       = 1'b1;
    next_n      = 3'b111;
    teller_en   = 3'b111;
    queue_count = 4'd0;
    #3;
    check_reset_outputs("reset");
    idle(3);
    reset = 1'b0;

    // Single press on teller 1
    queue_count = 4'd3;
    next_n      = 3'b110;
    wait_grant("single");
    check_grant("single", 1, 1);
    exp_dec++;
    next_n = 3'b111;
    hold_announce("single", 1);
    idle(40);
    check("single_dec_count", 32'(dec_count), exp_dec);

    // Bouncing teller 2 for two ticks, then released
    for (int i = 0; i < 8; i++) begin
      next_n[1] = ~next_n[1];
      @(negedge clk);
    end
    next_n = 3'b111;
    idle(60);
    check("bounce_dec_count", 32'(dec_count), exp_dec);
    check("bounce_rej_count", 32'(rej_count), 0);
    check("bounce_busy",      32'(busy), 0);

    // Fresh reset, then tellers 1 and 3 together
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    queue_count = 4'd5;
    next_n      = 3'b010;
    wait_grant("sim1");
    check_grant("sim1", 1, 1);
    exp_dec++;
    next_n = 3'b111;
    hold_announce("sim1", 1);
    @(negedge clk);
    check("sim_gap_dec", 32'(dec_pulse), 1);
    check_grant("sim2", 3, 2);
    exp_dec++;
    hold_announce("sim2", 3);
    idle(40);
    check("sim_dec_count", 32'(dec_count), exp_dec);

    // Lone teller 2, then all three: pointer now at teller 3
    next_n = 3'b101;
    wait_grant("lone2");
    check_grant("lone2", 2, 3);
    exp_dec++;
    next_n = 3'b111;
    hold_announce("lone2", 2);
    idle(40);

    next_n = 3'b000;
    wait_grant("rr1");
    check_grant("rr1", 3, 4);
    exp_dec++;
    next_n = 3'b111;
    hold_announce("rr1", 3);
    @(negedge clk);
    check("rr_gap1_dec", 32'(dec_pulse), 1);
    check_grant("rr2", 1, 5);
    exp_dec++;
    hold_announce("rr2", 1);
    @(negedge clk);
    check("rr_gap2_dec", 32'(dec_pulse), 1);
    check_grant("rr3", 2, 6);
    exp_dec++;
    hold_announce("rr3", 2);
    idle(40);
    check("rr_dec_count", 32'(dec_count), exp_dec);

    // Empty queue: press on teller 2 is rejected once
    queue_count = 4'd0;
    next_n      = 3'b101;
    for (int i = 0; i < 400; i++) begin
      if (reject_pulse === 1'b1) break;
      @(negedge clk);
    end
    check("empty_reject_seen", 32'(reject_pulse), 1);
    next_n = 3'b111;
    idle(40);
    check("empty_rej_count", 32'(rej_count), 1);
    check("empty_dec_count", 32'(dec_count), exp_dec);
    check("empty_teller",    32'(called_teller), 2);
    check("empty_ticket",    32'(called_ticket), 6);
    check("empty_busy",      32'(busy), 0);

    // Closed teller 3 is ignored
    queue_count = 4'd3;
    teller_en   = 3'b011;
    next_n      = 3'b011;
    idle(80);
    check("closed_dec_count", 32'(dec_count), exp_dec);
    check("closed_rej_count", 32'(rej_count), 1);
    check("closed_busy",      32'(busy), 0);
    next_n = 3'b111;
    idle(40);
    teller_en = 3'b111;

    // Ten served requests: ticket runs 7,8,9,0,...,6
    exp_ticket = 6;
    for (int i = 0; i < 10; i++) begin
      exp_ticket = (exp_ticket == 9) ? 0 : exp_ticket + 1;
      next_n = 3'b110;
      wait_grant("wrap");
      check_grant("wrap", 1, exp_ticket);
      exp_dec++;
      next_n = 3'b111;
      hold_announce("wrap", 1);
      idle(30);
    end
    check("wrap_dec_count", 32'(dec_count), exp_dec);

    // Reset during ANNOUNCE
    next_n = 3'b101;
    wait_grant("rst_pre");
    check_grant("rst_pre", 2, 7);
    exp_dec++;
    next_n = 3'b111;
    idle(2);
    check("rst_pre_in_announce", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    idle(3);
    reset = 1'b0;
    idle(40);
    check("rst_dec_count", 32'(dec_count), exp_dec);
    check_reset_outputs("rst_after");

    // Pointer restarts at teller 1
    next_n = 3'b000;
    wait_grant("post_rst");
    check_grant("post_rst", 1, 1);
    next_n = 3'b111;
    hold_announce("post_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/teller_call_dispatcher.md
# teller_call_dispatcher

Consumer side of the bank-queue subsystem. The entry path raises the people count; this block serves tellers. It takes "next customer" buttons from up to three tellers and debounces them. It arbitrates them round-robin and issues one decrement pulse per served customer to the people counter. It drives the called ticket digit and the called-teller indication for the seven-segment and LED outputs.

## Interface
Parameters:
- CLK_DIV, 1_000_000: clk cycles per sample tick.
- DB_SAMPLES, 3: consecutive equal tick samples required to accept a button level.
- HOLD_TICKS, 4: ticks the announcement is held after a grant.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- next_n  in  3  teller "next" buttons, active-low, raw (bit i = teller i+1).
- teller_en  in  3  teller desk open (from the teller switches); a closed teller is never served.
- queue_count  in  4  current people count, 0..7.
- dec_pulse  out  1  one-clk pulse requesting the counter to decrement by one.
- reject_pulse  out  1  one-clk pulse when a request is dropped because queue_count==0.
- called_teller  out  2  teller being announced, 1..3; 0 = none.
- called_ticket  out  4  ticket digit, BCD 0..9.
- call_led  out  3  one-hot, granted teller lit during the announcement.
- busy  out  1  high while in GRANT or ANNOUNCE.

## Operation
- **Tick divider:** the counter wraps at CLK_DIV-1. tick is high for one clk per period.
- **Debounce:** each next_n bit is sampled only on tick. The accepted level changes after DB_SAMPLES consecutive equal samples. The accepted level resets to 1 (released).
- **Edge detection:** a 1→0 change of the accepted level sets pending[i]. It sets it only if teller_en[i]=1.
  - A press on an already pending teller has no effect.
  - teller_en[i]=0 clears pending[i] every cycle.
- **FSM states:** IDLE, GRANT, ANNOUNCE.
  - **IDLE:** if pending≠0 and queue_count≠0, select the winner round-robin from ptr (search order ptr, ptr+1, ptr+2 mod 3) and go to GRANT.
  - **IDLE, empty queue:** if pending≠0 and queue_count==0, clear all pending, pulse reject_pulse for one clk, and stay in IDLE.
  - **GRANT (exactly 1 clk):**
    - dec_pulse=1.
    - Clear pending[win].
    - called_teller=win+1 and call_led=1<<win.
    - called_ticket increments, wrapping 9→0.
    - ptr=(win+1) mod 3.
    - Go to ANNOUNCE.
  - **ANNOUNCE:** stays for HOLD_TICKS ticks, then returns to IDLE.
    - call_led clears on exit.
    - called_teller and called_ticket hold their values until the next grant.
    - New presses still set pending.
- **Serialisation:** at most one dec_pulse per GRANT, so the decrements can never exceed the number of grants. queue_count is re-checked in IDLE before every grant.
- **Reset values:**
  - ptr = teller 1; FSM = IDLE; all pending = 0.
  - dec_pulse=0, reject_pulse=0, called_teller=0, called_ticket=0, call_led=0, busy=0.

## Timing
- The pending bit sets on the clk after the tick that accepts the press.
- IDLE→GRANT takes 1 clk after pending becomes nonzero. dec_pulse is registered, asserted during the GRANT cycle.
- ANNOUNCE length is HOLD_TICKS full tick periods: count HOLD_TICKS tick edges.
- **Simultaneous presses:** both pending bits set. The round-robin winner is served first. The other teller is granted one clk after ANNOUNCE exits, provided queue_count≠0 then.
- **Queue drains mid-announcement:** if queue_count reaches 0 while a request is pending, the request is rejected on return to IDLE.
- **Reset mid-ANNOUNCE:** all state returns to reset values immediately (asynchronous). No dec_pulse is issued.
- **Counter clock domain:** the people counter must sample dec_pulse in the clk domain.

## Structure
- **Package queue_pkg:**
  - MAX_PEOPLE=7 and N_TELLERS=3.
  - typedef of the state enum {IDLE, GRANT, ANNOUNCE}.
  - typedef teller_id_t (2 bits).
  - BCD wrap constant 9.
- **Sub-module button_debouncer:** clk, reset, tick, raw_n → level_n, fall. Instantiated three times.
- The top holds the divider, pending register, arbiter, FSM and output registers.

## Test plan
Bench uses CLK_DIV=4, DB_SAMPLES=3, HOLD_TICKS=2.
- **Single press:** queue_count=3, teller_en=111, next_n[0] held low ≥3 ticks → exactly one dec_pulse, called_teller=1, called_ticket=1, call_led=001 for 2 ticks, then busy=0.
- **Bounce:** next_n[1] toggled every clk for 2 ticks, then released → no pending, no dec_pulse.
- **Simultaneous presses:** next_n[0] and next_n[2] pressed together, queue_count=5 → grants to teller 1 then teller 3, two dec_pulses, called_ticket goes 1 then 2. Next lone presses rotate starting at teller 2.
- **Empty queue:** queue_count=0 with a press on teller 2 → reject_pulse once, no dec_pulse, called_teller unchanged.
- **Closed teller and wrap:** teller_en=011 with a press on teller 3 → ignored. Ten served requests → called_ticket wraps 9→0.
- **Reset mid-ANNOUNCE:** reset asserted during ANNOUNCE → every output returns to its reset value within the same cycle, and ptr restarts at teller 1.
